// File: rtl/prog_updown_counter.sv
// Programmable-modulus up/down counter: runtime modulus and step, sync clear/load, terminal-count pulse.
// Latency: o_q, o_tc and o_dir are registered and update on the same rising edge, one cycle after inputs are sampled.
// Backpressure: none; the counter advances on every cycle that i_en is high. Ping-pong mode 3 exists only with UDC_PINGPONG_EN.
module prog_updown_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_up_down,
  input  logic [WIDTH-1:0] i_mod,
  input  logic [WIDTH-1:0] i_step,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_dir,
  output logic             o_zero
);

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
`ifdef UDC_PINGPONG_EN
  localparam logic [1:0] MODE_PP   = 2'd3;
`endif

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  dir_e             dir_q, dir_d;

  // Modulus/step arithmetic. Results that are always < M fit in WIDTH bits,
  // so they are computed modulo 2^WIDTH (i_mod==0 then naturally means 2^WIDTH).
  // Only the comparisons need the extra bit.
  logic [WIDTH:0]   mod_x;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   q_x;
  logic [WIDTH:0]   s_x;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] mod_m1;
  logic [WIDTH-1:0] s_w;
  logic [WIDTH-1:0] load_clamped;
  logic             out_of_range;
  logic             mod_is_one;
  dir_e             dir_eff;
`ifdef UDC_PINGPONG_EN
  logic             pingpong;
`endif

  // Effective modulus, clamped step and clamped load value
  always_comb begin
    mod_x        = (i_mod == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, i_mod};
    mod_m1       = i_mod - {{(WIDTH-1){1'b0}}, 1'b1};
    step_x       = {1'b0, i_step};
    s_w          = (step_x >= mod_x) ? mod_m1 : i_step;
    s_x          = {1'b0, s_w};
    q_x          = {1'b0, q_q};
    sum_x        = q_x + s_x;
    load_clamped = ({1'b0, i_load_val} >= mod_x) ? mod_m1 : i_load_val;
    out_of_range = (q_x >= mod_x);
    mod_is_one   = (i_mod == {{(WIDTH-1){1'b0}}, 1'b1});
  end

  // Direction requested by the mode for this cycle; ping-pong keeps the stored state
  always_comb begin
    dir_eff = dir_q;
`ifdef UDC_PINGPONG_EN
    pingpong = 1'b0;
`endif
    case (i_mode)
      MODE_UP:   dir_eff = DIR_UP;
      MODE_DOWN: dir_eff = DIR_DOWN;
`ifdef UDC_PINGPONG_EN
      MODE_PP: begin
        dir_eff  = dir_q;
        pingpong = 1'b1;
      end
`endif
      default:   dir_eff = i_up_down ? DIR_UP : DIR_DOWN;
    endcase
  end

  // Next count, terminal-count pulse and direction in priority order
  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    dir_d = dir_q;
    if (i_clr) begin
      q_d   = '0;
      dir_d = DIR_UP;
    end else if (i_load) begin
      q_d = load_clamped;
    end else if (out_of_range) begin
      // Modulus lowered under the current count: snap back to 0 silently
      q_d = '0;
    end else if (i_en) begin
      dir_d = dir_eff;
      if (mod_is_one) begin
        // Single-state counter: every nonzero step is a wrap (or bounce)
        q_d  = '0;
        tc_d = (i_step != '0);
`ifdef UDC_PINGPONG_EN
        if (pingpong && (i_step != '0)) begin
          dir_d = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
        end
`endif
      end else if (s_w == '0) begin
        q_d = q_q;
`ifdef UDC_PINGPONG_EN
      end else if (pingpong) begin
        if (dir_q == DIR_UP) begin
          if (sum_x >= {1'b0, mod_m1}) begin
            q_d   = mod_m1;
            dir_d = DIR_DOWN;
            tc_d  = 1'b1;
          end else begin
            q_d = q_q + s_w;
          end
        end else begin
          if (q_x <= s_x) begin
            q_d   = '0;
            dir_d = DIR_UP;
            tc_d  = 1'b1;
          end else begin
            q_d = q_q - s_w;
          end
        end
`endif
      end else if (dir_eff == DIR_UP) begin
        if (sum_x >= mod_x) begin
          q_d  = q_q + s_w - i_mod;
          tc_d = 1'b1;
        end else begin
          q_d = q_q + s_w;
        end
      end else begin
        if (q_x < s_x) begin
          q_d  = q_q + i_mod - s_w;
          tc_d = 1'b1;
        end else begin
          q_d = q_q - s_w;
        end
      end
    end
  end

  // State register: count, terminal-count pulse and direction FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      dir_q <= DIR_UP;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      dir_q <= dir_d;
    end
  end

  assign o_q    = q_q;
  assign o_tc   = tc_q;
  assign o_dir  = (dir_q == DIR_UP);
  assign o_zero = (q_q == '0);

endmodule

// File: doc/prog_updown_counter.md
# prog_updown_counter

Parametrised, programmable-modulus up/down counter with runtime step size, synchronous load/clear, terminal-count pulse and optional ping-pong (bounce) mode. It is the general-purpose successor to the team's fixed-N up/down counter. It serves as a drop-in sequencer/index generator for address walkers, PWM timebases and test pattern sources.

## Interface
Parameters:
- WIDTH, 8: counter width; count range 0..M-1 with M ≤ 2^WIDTH.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_clr  in  1  synchronous clear, highest priority after reset.
- i_load  in  1  synchronous load of i_load_val.
- i_load_val  in  WIDTH  load value.
- i_en  in  1  count enable.
- i_mode  in  2  0=up, 1=down, 2=external direction, 3=ping-pong.
- i_up_down  in  1  direction in mode 2 (1=up, 0=down).
- i_mod  in  WIDTH  modulus; 0 means M=2^WIDTH.
- i_step  in  WIDTH  increment per enabled cycle.
- o_q  out  WIDTH  registered count.
- o_tc  out  1  registered terminal-count pulse, high one cycle per wrap/bounce.
- o_dir  out  1  current direction (1=up).
- o_zero  out  1  o_q == 0, combinational from o_q.

## Operation
- M = (i_mod==0) ? 2^WIDTH : i_mod. Effective step s = (i_step ≥ M) ? M-1 : i_step. All sums use WIDTH+1 bits.
- Priority per cycle: i_clr, then i_load, then out-of-range fix, then i_en count, else hold.
- i_clr: q←0, o_tc←0, dir←up.
- i_load: q←(i_load_val ≥ M) ? M-1 : i_load_val; o_tc←0; dir unchanged.
- Out-of-range: if q ≥ M (modulus lowered mid-run), q←0 on the next edge regardless of i_en; no o_tc.
- Direction FSM, two states: UP and DOWN. Mode 0 forces UP. Mode 1 forces DOWN. Mode 2 follows i_up_down each cycle. Mode 3 keeps the state and flips only on a bounce.
- Up, modes 0/2: sum=q+s. If sum ≥ M, q←sum-M and o_tc←1. Else q←sum.
- Down, modes 1/2: if q < s, q←q+M-s and o_tc←1. Else q←q-s.
- Ping-pong UP: if q+s ≥ M-1, q←M-1, state→DOWN, o_tc←1. Else q←q+s.
- Ping-pong DOWN: if q ≤ s, q←0, state→UP, o_tc←1. Else q←q-s.
- s=0: q holds; o_tc is 0.
- M=1: q stays 0. o_tc pulses on every enabled cycle where i_step≠0.
- i_en low: q and dir hold; o_tc←0.

## Timing
- Reset values: o_q=0, o_tc=0, o_dir=1, o_zero=1.
- All inputs are sampled on the rising edge of i_clk. o_q, o_tc and o_dir update on that same edge, giving 1-cycle latency.
- o_tc is high in exactly the cycle in which o_q shows the wrapped/bounced value.
- Mode or modulus changes take effect at the next edge. No pipeline or flush is required.
- i_rst asserted mid-count clears all state immediately, independent of the clock. Counting resumes at the first edge after deassertion, starting from 0 in the UP state.

## Configuration
- Macro UDC_PINGPONG_EN.
- Defined: mode 3 behaves as ping-pong as specified above.
- Undefined: the ping-pong logic is not compiled. Mode 3 behaves exactly as mode 2.

## Test plan
- Reset, then WIDTH=8, i_mod=10, i_step=1, mode 0, i_en=1 for 12 cycles: o_q runs 0..9,0,1. o_tc is high only in the cycle o_q=0 after 9.
- Mode 1, i_mod=10, i_step=3, from q=0: o_q sequence is 7,4,1,8. o_tc is high on 7 and on 8.
- Mode 3 with UDC_PINGPONG_EN, i_mod=6, i_step=2, from 0: o_q is 2,4,5,3,1,0,2. o_dir flips after 5 and after 0. o_tc is high on 5 and on 0. Without the macro, the same stimulus with i_up_down=1 gives 2,4,0.
- At q=8, i_mod=10: set i_mod=5 with i_en=0. Next edge: o_q=0, o_tc=0.
- Same cycle i_clr=1, i_load=1, i_en=1: o_q=0. Next, i_load=1 with i_load_val=200, i_mod=50: o_q=49.
- i_mod=1, i_step=1, mode 0: o_q stays 0 and o_tc is high every enabled cycle. Asynchronous i_rst pulse mid-cycle: o_q=0 and o_tc=0 immediately.
